// File: rtl/brent_kung_adder.sv
// Brent-Kung parallel-prefix adder with a registered {cout,sum} result.
// The carry network is built structurally; cin enters as the bit -1 generate.
module brent_kung_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int LOG  = $clog2(WIDTH);
   localparam int NLVL = 2 * LOG - 1;

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_d;

   // Level 0 holds bit-level g/p; levels 1..LOG are the up-sweep and
   // levels LOG+1..NLVL the down-sweep. Each level owns its own g/p vectors.
   for (genvar s = 0; s <= NLVL; s++) begin : g_lvl
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;

      if (s == 0) begin : g_bit
         assign g = A & B;
         assign p = A ^ B;
      end else begin : g_node
         for (genvar i = 0; i < WIDTH; i++) begin : g_col
            localparam bit UP    = (s <= LOG);
            localparam int SPAN  = UP ? (1 << (s - 1)) : (1 << (NLVL - s));
            localparam int POS   = (i + 1) % (2 * SPAN);
            localparam bit HIT   = UP ? (POS == 0) : ((POS == SPAN) && (i + 1 > 2 * SPAN));

            if (HIT) begin : g_op
               assign g[i] = g_lvl[s-1].g[i] | (g_lvl[s-1].p[i] & g_lvl[s-1].g[i-SPAN]);
               assign p[i] = g_lvl[s-1].p[i] & g_lvl[s-1].p[i-SPAN];
            end else begin : g_pass
               assign g[i] = g_lvl[s-1].g[i];
               assign p[i] = g_lvl[s-1].p[i];
            end
         end
      end
   end

   // Group terms G[i:0]/P[i:0] exclude cin, so it is folded in here.
   assign c[0] = cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_carry
      assign c[i+1] = g_lvl[NLVL].g[i] | (g_lvl[NLVL].p[i] & cin);
   end

   assign sum_d = g_lvl[0].p ^ c[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= sum_d;
         cout <= c[WIDTH];
      end
   end

endmodule

// File: tb/tb_brent_kung_adder.sv
// Directed and cross-product checks of brent_kung_adder, including async reset.
module tb_brent_kung_adder;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int n_vec;
   int n_err;

   brent_kung_adder #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (A),
      .B    (B),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                        input logic [WIDTH:0] exp, input string tag);
      A   = a;
      B   = b;
      cin = ci;
      step();
      $display("%s: %h + %h + %0d = %h", tag, a, b, ci, {cout, sum});
      check(tag, {cout, sum}, exp);
   endtask

   logic [WIDTH-1:0] vecs [0:19];
   logic [WIDTH:0]   model;

   initial begin
      n_vec = 0;
      n_err = 0;
      vecs = '{16'h0000, 16'h0001, 16'h0002, 16'h000F, 16'h0010, 16'h00FF, 16'h0100,
               16'h1234, 16'h4321, 16'h5555, 16'hAAAA, 16'h7FFF, 16'h8000, 16'h8001,
               16'hBEEF, 16'hC3A5, 16'hF0F0, 16'hFF00, 16'hFFFE, 16'hFFFF};

      // Reset asserted with all-ones inputs: outputs 0 before any edge.
      rst_n = 1'b0;
      A     = 16'hFFFF;
      B     = 16'hFFFF;
      cin   = 1'b1;
      #3;
      check("reset_no_edge", {cout, sum}, 17'h0_0000);
      step();
      step();
      check("reset_after_edges", {cout, sum}, 17'h0_0000);

      rst_n = 1'b1;
      apply(16'h0000, 16'h0000, 1'b0, 17'h0_0000, "zero");
      apply(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, "ffff_plus_1");
      apply(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, "ffff_ffff_cin");
      apply(16'h8000, 16'h8000, 1'b0, 17'h1_0000, "msb_carry");
      apply(16'h1234, 16'h4321, 1'b0, 17'h0_5555, "no_carry");
      apply(16'h7FFF, 16'h0000, 1'b1, 17'h0_8000, "cin_ripple");
      apply(16'h00FF, 16'h0001, 1'b1, 17'h0_0101, "byte_ripple");
      apply(16'h0000, 16'h0000, 1'b1, 17'h0_0001, "cin_only");

      // Input changes between edges must not reach the outputs.
      A = 16'h1111;
      B = 16'h2222;
      cin = 1'b0;
      #3;
      check("hold_between_edges", {cout, sum}, 17'h0_0001);
      step();
      check("after_hold", {cout, sum}, 17'h0_3333);

      // Cross product, one vector per cycle, checked one cycle later.
      for (int i = 0; i < 20; i++) begin
         for (int j = 0; j < 20; j++) begin
            A   = vecs[i];
            B   = vecs[j];
            cin = 1'b0;
            model = {1'b0, vecs[i]} + {1'b0, vecs[j]};
            step();
            $display("xp %h + %h = %h", vecs[i], vecs[j], {cout, sum});
            check("cross", {cout, sum}, model);
         end
      end

      // Mid-stream reset pulse: clear immediately, first edge after release adds.
      apply(16'hABCD, 16'h1111, 1'b1, 17'h0_BCDF, "pre_reset");
      A   = 16'hFFF0;
      B   = 16'h0020;
      cin = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("midstream_reset", {cout, sum}, 17'h0_0000);
      step();
      check("reset_held_edge", {cout, sum}, 17'h0_0000);
      rst_n = 1'b1;
      step();
      check("after_release", {cout, sum}, 17'h1_0011);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
